// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Definitions shared by the PS/2 device and host blocks: link
//               state encoding, frame length and the odd-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    BIT_HIGH  = 3'd2,
    BIT_LOW   = 3'd3,
    DONE      = 3'd4,
    ABORT     = 3'd5
  } ps2_state_e;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] i_d);
    return ~^i_d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync
// Description : Two-flop synchronizer for one asynchronous PS/2 line. Resets
//               to 1, the released (pulled-up) level of an open-drain line.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               i_d   - asynchronous line level
//               o_q   - synchronized line level
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ps2_dev_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_dev_tx
// Description : Device-side PS/2 transmitter. Generates the PS/2 clock and
//               shifts out one 11-bit frame (start, 8 data LSB first, odd
//               parity, stop) per accepted byte. Host inhibit is honoured by
//               deferring the start or aborting and resending the same byte.
// Ports       : clk        - system clock
//               reset      - asynchronous active-low reset
//               tx_data    - byte to send
//               tx_valid   - byte available
//               tx_ready   - block can accept a byte (state is IDLE)
//               tx_done    - 1-cycle pulse, frame completed
//               tx_abort   - 1-cycle pulse, frame aborted, retry pending
//               host_rts   - host request-to-send seen while idle
//               ps2clk_in  - PS/2 clock line level (async)
//               ps2data_in - PS/2 data line level (async)
//               ps2clk_oe  - 1 = pull clock low
//               ps2data_oe - 1 = pull data low
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_dev_tx
  import ps2_pkg::*;
#(
  parameter int HALF_CYC = 4000,
  parameter int IDLE_CYC = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       host_rts,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);

  localparam int CNT_MAX = (HALF_CYC > IDLE_CYC) ? HALF_CYC : IDLE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] c_idle_last = CNT_W'(IDLE_CYC - 1);
  localparam logic [3:0]       c_bit_last  = 4'(FRAME_BITS - 1);

  // Synchronized line levels
  logic w_clk_s;
  logic w_data_s;

  ps2_sync u_sync_clk (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (ps2clk_in),
    .o_q   (w_clk_s)
  );

  ps2_sync u_sync_data (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (ps2data_in),
    .o_q   (w_data_s)
  );

  ps2_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shreg;
  logic             r_par;
  logic             r_clk_oe;
  logic             r_data_oe;
  logic             r_done;
  logic             r_abort;
  logic             r_rts;

  ps2_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_bit_nxt;
  logic             w_load;
  logic             w_clk_oe_nxt;
  logic             w_data_oe_nxt;
  logic             w_done_nxt;
  logic             w_abort_nxt;
  logic             w_rts_nxt;
  logic [10:0]      w_frame;

  assign w_frame = {1'b1, r_par, r_shreg, 1'b0};

  // State register; line drives and pulses are registered so the open-drain
  // enables never glitch on state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_rts     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_done    <= w_done_nxt;
      r_abort   <= w_abort_nxt;
      r_rts     <= w_rts_nxt;
      if (w_load) begin
        r_shreg <= tx_data;
        r_par   <= odd_parity(tx_data);
      end
    end
  end

  // Next-state logic. The shared counter restarts on every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit_cnt;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        // A pending host request-to-send takes priority over new bytes
        if (tx_valid && !r_rts) begin
          w_load      = 1'b1;
          w_state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // Bus must stay idle for IDLE_CYC consecutive cycles
        if (!(w_clk_s && w_data_s)) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_idle_last) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nxt = '0;
          // Clock was released; a low level here means the host is inhibiting
          w_state_nxt = w_clk_s ? BIT_LOW : ABORT;
        end
      end
      BIT_LOW: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nxt = '0;
          if (r_bit_cnt == c_bit_last) begin
            w_state_nxt = DONE;
          end else begin
            w_bit_nxt   = r_bit_cnt + 4'd1;
            w_state_nxt = BIT_HIGH;
          end
        end
      end
      DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      ABORT: begin
        // shreg/par are held so the retry resends the same byte
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output logic, decoded from the upcoming state
  always_comb begin
    w_clk_oe_nxt  = (w_state_nxt == BIT_LOW);
    w_data_oe_nxt = 1'b0;
    if ((w_state_nxt == BIT_HIGH) || (w_state_nxt == BIT_LOW)) begin
      w_data_oe_nxt = ~w_frame[w_bit_nxt];
    end
    w_done_nxt  = (w_state_nxt == DONE);
    w_abort_nxt = (w_state_nxt == ABORT);
    w_rts_nxt   = (w_state_nxt == IDLE) && w_clk_s && !w_data_s;
  end

  assign tx_ready   = (r_state == IDLE);
  assign tx_done    = r_done;
  assign tx_abort   = r_abort;
  assign host_rts   = r_rts;
  assign ps2clk_oe  = r_clk_oe;
  assign ps2data_oe = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_dev_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_dev_tx
// Description : Self-checking bench for ps2_dev_tx. Open-drain bus with
//               pull-ups; the host side can pull either line low. Device
//               clock falls are captured together with the data line level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_dev_tx;

  localparam int HALF = 8;
  localparam int IDLE = 10;
  localparam int CP   = 10;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_abort;
  logic       host_rts;
  logic       ps2clk_oe;
  logic       ps2data_oe;
  logic       host_clk_pull;
  logic       host_data_pull;
  wire        bus_clk  = ~(ps2clk_oe | host_clk_pull);
  wire        bus_data = ~(ps2data_oe | host_data_pull);

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic rx_bits[$];
  time  fall_t[$];

  ps2_dev_tx #(.HALF_CYC(HALF), .IDLE_CYC(IDLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort),
    .host_rts   (host_rts),
    .ps2clk_in  (bus_clk),
    .ps2data_in (bus_data),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe)
  );

  initial clk = 1'b0;
  always #(CP / 2) clk = ~clk;

  // Host receiver model: the device pulling the clock low is a falling edge
  always @(posedge ps2clk_oe) begin
    rx_bits.push_back(bus_data);
    fall_t.push_back($time);
  end

  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (tx_abort) abort_cnt++;
  end

  function automatic logic [10:0] got_frame(input int base);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < 11; i++) if (base + i < rx_bits.size()) f[i] = rx_bits[base + i];
    return f;
  endfunction

  task automatic clear_mon();
    rx_bits.delete();
    fall_t.delete();
    done_cnt  = 0;
    abort_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, output time t_hs, output bit ok);
    ok   = 1'b0;
    t_hs = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready && !host_rts) begin
        @(posedge clk);
        t_hs = $time;
        #1 tx_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ps2clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe got=%b exp=0", ps2clk_oe); end
    n_checks++; if (ps2data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got=%b exp=0", ps2data_oe); end
    n_checks++; if ({tx_done, tx_abort, host_rts} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {tx_done, tx_abort, host_rts}); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_1c();
    time t_hs; bit ok; logic [10:0] f;
    clear_mon();
    send_byte(8'h1C, t_hs, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL s1c_handshake got=timeout exp=handshake"); end
    wait_done(1, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL s1c_done got=timeout exp=tx_done"); end
    repeat (4) @(negedge clk);
    f = got_frame(0);
    n_checks++; if (rx_bits.size() != 11) begin n_fail++; $display("FAIL s1c_edges got=%0d exp=11", rx_bits.size()); end
    n_checks++; if (f !== 11'b1_0_00011100_0) begin n_fail++; $display("FAIL s1c_frame got=%b exp=%b", f, 11'b1_0_00011100_0); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL s1c_done_count got=%0d exp=1", done_cnt); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL s1c_ready got=%b exp=1", tx_ready); end
    if (fall_t.size() == 11) begin
      n_checks++;
      if ((fall_t[0] - t_hs) < time'((IDLE + HALF) * CP) || (fall_t[0] - t_hs) > time'((IDLE + HALF + 2) * CP)) begin
        n_fail++; $display("FAIL s1c_first_fall got=%0t exp=%0d..%0d cycles*10", fall_t[0] - t_hs, IDLE + HALF, IDLE + HALF + 2);
      end
      n_checks++;
      if ((fall_t[10] - fall_t[0]) != time'(20 * HALF * CP)) begin
        n_fail++; $display("FAIL s1c_frame_span got=%0t exp=%0d", fall_t[10] - fall_t[0], 20 * HALF * CP);
      end
    end
  endtask

  task automatic test_send_00();
    time t_hs; bit ok; logic [10:0] f;
    clear_mon();
    send_byte(8'h00, t_hs, ok);
    wait_done(1, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL s00_done got=timeout exp=tx_done"); end
    repeat (2) @(negedge clk);
    f = got_frame(0);
    n_checks++; if (f[8:1] !== 8'h00) begin n_fail++; $display("FAIL s00_data got=%h exp=00", f[8:1]); end
    n_checks++; if (f[9] !== 1'b1) begin n_fail++; $display("FAIL s00_parity got=%b exp=1", f[9]); end
    n_checks++; if ({f[10], f[0]} !== 2'b10) begin n_fail++; $display("FAIL s00_stop_start got=%b exp=10", {f[10], f[0]}); end
  endtask

  task automatic test_host_rts();
    int falls0;
    falls0 = fall_t.size();
    @(negedge clk);
    host_data_pull = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (host_rts !== 1'b1) begin n_fail++; $display("FAIL rts_seen got=%b exp=1", host_rts); end
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rts_valid_ignored got_ready=%b exp=1", tx_ready); end
    tx_valid = 1'b0;
    host_data_pull = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (host_rts !== 1'b0) begin n_fail++; $display("FAIL rts_clear got=%b exp=0", host_rts); end
    repeat (IDLE + HALF + 4) @(negedge clk);
    n_checks++; if (fall_t.size() != falls0) begin n_fail++; $display("FAIL rts_no_frame got=%0d exp=%0d", fall_t.size(), falls0); end
  endtask

  task automatic test_inhibit_defer();
    time t_hs, t_rel; bit ok;
    clear_mon();
    @(negedge clk);
    host_clk_pull = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'hF0, t_hs, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL defer_handshake got=timeout exp=handshake"); end
    repeat (95) @(negedge clk);
    n_checks++; if (fall_t.size() != 0) begin n_fail++; $display("FAIL defer_no_clock got=%0d exp=0", fall_t.size()); end
    @(posedge clk);
    t_rel = $time;
    #1 host_clk_pull = 1'b0;
    wait_done(1, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL defer_done got=timeout exp=tx_done"); end
    if (fall_t.size() > 0) begin
      n_checks++;
      if ((fall_t[0] - t_rel) != time'((IDLE + HALF + 2) * CP)) begin
        n_fail++; $display("FAIL defer_first_fall got=%0t exp=%0d", fall_t[0] - t_rel, (IDLE + HALF + 2) * CP);
      end
    end
    n_checks++; if (got_frame(0) !== 11'b1_1_11110000_0) begin n_fail++; $display("FAIL defer_frame got=%b exp=%b", got_frame(0), 11'b1_1_11110000_0); end
  endtask

  task automatic test_abort_retry();
    time t_hs, t_n0; bit ok; bit seen;
    clear_mon();
    send_byte(8'hF0, t_hs, ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fall_t.size() >= 5) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_reach_bit5 got=timeout exp=5 falls"); end
    // End of bit 4 low phase = start of bit 5 high phase
    t_n0 = 0;
    for (int i = 0; i < 40; i++) begin
      if (ps2clk_oe === 1'b0) begin t_n0 = $time; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    host_clk_pull = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_abort) begin
        seen = 1'b1;
        n_checks++; if ($time - t_n0 != time'(HALF * CP)) begin n_fail++; $display("FAIL abort_timing got=%0t exp=%0d", $time - t_n0, HALF * CP); end
        n_checks++; if ({ps2clk_oe, ps2data_oe} !== 2'b00) begin n_fail++; $display("FAIL abort_release got=%b exp=00", {ps2clk_oe, ps2data_oe}); end
        break;
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_pulse got=none exp=tx_abort"); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    n_checks++; if (fall_t.size() != 5) begin n_fail++; $display("FAIL abort_falls got=%0d exp=5", fall_t.size()); end
    rx_bits.delete();
    fall_t.delete();
    repeat (20) @(negedge clk);
    host_clk_pull = 1'b0;
    wait_done(1, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL retry_done got=timeout exp=tx_done"); end
    n_checks++; if (got_frame(0) !== 11'b1_1_11110000_0) begin n_fail++; $display("FAIL retry_frame got=%b exp=%b", got_frame(0), 11'b1_1_11110000_0); end
    n_checks++; if (abort_cnt != 1 || rx_bits.size() != 11) begin n_fail++; $display("FAIL retry_counts got_abort=%0d got_bits=%0d exp=1,11", abort_cnt, rx_bits.size()); end
  endtask

  task automatic test_reset_mid_frame();
    time t_hs; bit ok;
    clear_mon();
    send_byte(8'h00, t_hs, ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fall_t.size() >= 4) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach_bit3 got=timeout exp=4 falls"); end
    repeat (2) @(negedge clk);
    n_checks++; if ({ps2clk_oe, ps2data_oe} !== 2'b11) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=11", {ps2clk_oe, ps2data_oe}); end
    reset = 1'b0;
    #1;
    n_checks++; if ({ps2clk_oe, ps2data_oe} !== 2'b00) begin n_fail++; $display("FAIL rstmid_async got=%b exp=00", {ps2clk_oe, ps2data_oe}); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", tx_ready); end
    repeat (60) @(negedge clk);
    n_checks++; if (done_cnt != 0 || abort_cnt != 0 || fall_t.size() != 4) begin
      n_fail++; $display("FAIL rstmid_dropped got_done=%0d got_abort=%0d got_falls=%0d exp=0,0,4", done_cnt, abort_cnt, fall_t.size());
    end
  endtask

  task automatic test_back_to_back();
    int  n_hs;
    time t_hs2, t_done1;
    clear_mon();
    n_hs = 0; t_hs2 = 0; t_done1 = 0;
    @(negedge clk);
    tx_data  = 8'hE0;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (tx_done && t_done1 == 0) t_done1 = $time;
      if (done_cnt >= 2) break;
      if (tx_valid && tx_ready && !host_rts) begin
        @(posedge clk);
        n_hs++;
        if (n_hs == 2) t_hs2 = $time;
        #1;
        if (n_hs == 1) tx_data = 8'h75;
        else tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    n_checks++; if (done_cnt != 2 || n_hs != 2) begin n_fail++; $display("FAIL b2b_counts got_done=%0d got_hs=%0d exp=2,2", done_cnt, n_hs); end
    n_checks++; if (t_hs2 < t_done1 + CP / 2) begin n_fail++; $display("FAIL b2b_hs_after_done got=%0t exp>=%0t", t_hs2, t_done1 + CP / 2); end
    if (fall_t.size() == 22) begin
      n_checks++;
      if (fall_t[11] - t_done1 < time'(IDLE * CP)) begin n_fail++; $display("FAIL b2b_idle_gap got=%0t exp>=%0d", fall_t[11] - t_done1, IDLE * CP); end
    end
    n_checks++; if (got_frame(0) !== 11'b1_0_11100000_0) begin n_fail++; $display("FAIL b2b_first got=%b exp=%b", got_frame(0), 11'b1_0_11100000_0); end
    n_checks++; if (got_frame(11) !== 11'b1_0_01110101_0) begin n_fail++; $display("FAIL b2b_second got=%b exp=%b", got_frame(11), 11'b1_0_01110101_0); end
  endtask

  initial begin
    #(100000 * CP);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    tx_data        = 8'h00;
    tx_valid       = 1'b0;
    host_clk_pull  = 1'b0;
    host_data_pull = 1'b0;
    test_reset();
    test_send_1c();
    test_send_00();
    test_host_rts();
    test_inhibit_defer();
    test_abort_retry();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
